beep_seq_ctrl: RTL and testbench

//  Initiator side of the beep-timer interface: programs the external interval timer (preset,

---
 rtl/beep_seq_ctrl_pkg.sv | 22 ++
 rtl/beep_seq_ctrl_tone_gen.sv | 37 +++
 rtl/beep_seq_ctrl.sv | 119 +++++++++++
 tb/tb_beep_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_seq_ctrl_pkg.sv
// Shared types and constants for the beep sequencer and its tone generator.
package beep_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_ON  = 3'd1,
        ST_WAIT_ON  = 3'd2,
        ST_LOAD_OFF = 3'd3,
        ST_WAIT_OFF = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic        TMR_MODE_SINGLE = 1'b0;
    localparam int unsigned MIN_IV_DEFAULT  = 2;

    // Raise an interval request to the smallest value the timer handles.
    function automatic logic [31:0] clamp_iv(input logic [31:0] value,
                                             input logic [31:0] min_value);
        return (value < min_value) ? min_value : value;
    endfunction

endpackage

// File: rtl/beep_seq_ctrl_tone_gen.sv
// Square-wave tone generator: high on the first enabled cycle, toggles every
// half_period cycles, cleared whenever en is low.
module beep_seq_ctrl_tone_gen
    import beep_seq_ctrl_pkg::*;
#(
    parameter int unsigned TONE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [TONE_W-1:0] half_period,
    output logic              tone
);

    logic [TONE_W-1:0] cnt;
    logic              active;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt    <= '0;
            active <= 1'b0;
            tone   <= 1'b0;
        end else if (!active) begin
            cnt    <= '0;
            active <= 1'b1;
            tone   <= 1'b1;
        end else if (half_period == '0) begin
            tone <= 1'b1;
        end else if (cnt == half_period - 1'b1) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/beep_seq_ctrl.sv
// Beep sequencer: programs the external interval timer for alternating ON/OFF
// intervals and drives the buzzer tone during each ON interval.
module beep_seq_ctrl
    import beep_seq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_W  = 4,
    parameter int unsigned TONE_W = 16,
    parameter int unsigned MIN_IV = MIN_IV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              abort,
    input  logic [NUM_W-1:0]  beep_num,
    input  logic [31:0]       on_cyc,
    input  logic [31:0]       off_cyc,
    input  logic [TONE_W-1:0] tone_half,
    input  logic              tmr_full,
    output logic [31:0]       tmr_acc,
    output logic              tmr_mode,
    output logic              tmr_start,
    output logic              beep_out,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [NUM_W-1:0]  beeps_left;
    logic [31:0]       on_iv;
    logic [31:0]       off_iv;
    logic [TONE_W-1:0] half;
    logic              tone_en;

    assign tmr_mode = TMR_MODE_SINGLE;

    // Tone enable looks one edge ahead so beep_out is already high on the
    // first WAIT_ON cycle and already low on the cycle after leaving it.
    assign tone_en = !abort &&
                     ((state == ST_LOAD_ON) || ((state == ST_WAIT_ON) && !tmr_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            tmr_start  <= 1'b0;
            tmr_acc    <= '0;
            beeps_left <= '0;
            on_iv      <= '0;
            off_iv     <= '0;
            half       <= '0;
        end else begin
            done      <= 1'b0;
            tmr_start <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                beeps_left <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req && !abort) begin
                            beeps_left <= beep_num;
                            on_iv      <= clamp_iv(on_cyc, 32'(MIN_IV));
                            off_iv     <= clamp_iv(off_cyc, 32'(MIN_IV));
                            half       <= tone_half;
                            if (beep_num == '0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= ST_LOAD_ON;
                                busy      <= 1'b1;
                                tmr_acc   <= clamp_iv(on_cyc, 32'(MIN_IV));
                                tmr_start <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD_ON:  state <= ST_WAIT_ON;
                    ST_WAIT_ON: begin
                        if (tmr_full) begin
                            if (beeps_left <= 1) begin
                                beeps_left <= '0;
                                state      <= ST_DONE;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                            end else begin
                                beeps_left <= beeps_left - 1'b1;
                                state      <= ST_LOAD_OFF;
                                tmr_acc    <= off_iv;
                                tmr_start  <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD_OFF: state <= ST_WAIT_OFF;
                    ST_WAIT_OFF: begin
                        if (tmr_full) begin
                            state     <= ST_LOAD_ON;
                            tmr_acc   <= on_iv;
                            tmr_start <= 1'b1;
                        end
                    end
                    ST_DONE:     state <= ST_IDLE;
                    default:     state <= ST_IDLE;
                endcase
            end
        end
    end

    beep_seq_ctrl_tone_gen #(
        .TONE_W(TONE_W)
    ) u_tone (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .half_period (half),
        .tone        (beep_out)
    );

endmodule

// File: tb/tb_beep_seq_ctrl.sv
// Directed bench for beep_seq_ctrl; the bench plays the role of the interval timer.
module tb_beep_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        abort;
    logic [3:0]  beep_num;
    logic [31:0] on_cyc;
    logic [31:0] off_cyc;
    logic [15:0] tone_half;
    logic        tmr_full;
    logic [31:0] tmr_acc;
    logic        tmr_mode;
    logic        tmr_start;
    logic        beep_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int dones  = 0;
    int s0;
    int d0;

    beep_seq_ctrl #(
        .NUM_W  (4),
        .TONE_W (16),
        .MIN_IV (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .abort     (abort),
        .beep_num  (beep_num),
        .on_cyc    (on_cyc),
        .off_cyc   (off_cyc),
        .tone_half (tone_half),
        .tmr_full  (tmr_full),
        .tmr_acc   (tmr_acc),
        .tmr_mode  (tmr_mode),
        .tmr_start (tmr_start),
        .beep_out  (beep_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (tmr_start === 1'b1) starts++;
            if (done === 1'b1) dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_full();
        tmr_full = 1'b1;
        tick();
        tmr_full = 1'b0;
    endtask

    task automatic request(input logic [3:0] n, input logic [31:0] on_v,
                           input logic [31:0] off_v, input logic [15:0] half_v);
        beep_num  = n;
        on_cyc    = on_v;
        off_cyc   = off_v;
        tone_half = half_v;
        req       = 1'b1;
        tick();
        req       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; abort = 1'b0; tmr_full = 1'b0;
        beep_num = '0; on_cyc = '0; off_cyc = '0; tone_half = '0;
        ticks(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start", tmr_start, 0);
        chk("rst_beep", beep_out, 0);
        chk("rst_acc", tmr_acc, 0);
        chk("rst_mode", tmr_mode, 0);
        rst = 1'b0;
        tick();

        // Three beeps, tone half-period 4.
        s0 = starts; d0 = dones;
        request(4'd3, 32'd20, 32'd10, 16'd4);
        chk("m_start1", tmr_start, 1);
        chk("m_acc_on1", tmr_acc, 20);
        chk("m_busy", busy, 1);
        chk("m_beep_load", beep_out, 0);
        tick();
        chk("m_start_one_cycle", tmr_start, 0);
        for (int i = 0; i < 12; i++) begin
            chk("m_tone", beep_out, ((i / 4) % 2 == 0) ? 1 : 0);
            tick();
        end
        chk("m_acc_hold", tmr_acc, 20);
        pulse_full();
        chk("m_start_off1", tmr_start, 1);
        chk("m_acc_off1", tmr_acc, 10);
        chk("m_beep_off", beep_out, 0);
        chk("m_no_done", done, 0);
        tick();
        chk("m_start_drop", tmr_start, 0);
        ticks(3);
        chk("m_beep_woff", beep_out, 0);
        pulse_full();
        chk("m_acc_on2", tmr_acc, 20);
        tick(); ticks(4);
        pulse_full();
        chk("m_acc_off2", tmr_acc, 10);
        tick(); ticks(2);
        pulse_full();
        chk("m_acc_on3", tmr_acc, 20);
        tick(); ticks(3);
        pulse_full();
        chk("m_done", done, 1);
        chk("m_busy_drop", busy, 0);
        chk("m_beep_done", beep_out, 0);
        chk("m_start_done", tmr_start, 0);
        tick();
        chk("m_done_pulse", done, 0);
        tick();
        chk("m_start_count", starts - s0, 5);
        chk("m_done_count", dones - d0, 1);

        // Reset held for three cycles in the middle of WAIT_ON.
        d0 = dones;
        request(4'd2, 32'd5, 32'd5, 16'd2);
        tick(); ticks(2);
        rst = 1'b1;
        ticks(3);
        chk("r_busy", busy, 0);
        chk("r_beep", beep_out, 0);
        chk("r_start", tmr_start, 0);
        chk("r_done", done, 0);
        chk("r_acc", tmr_acc, 0);
        rst = 1'b0;
        tick();
        chk("r_idle_busy", busy, 0);
        chk("r_no_done", dones - d0, 0);
        request(4'd1, 32'd7, 32'd3, 16'd0);
        chk("r_restart", tmr_start, 1);
        chk("r_acc7", tmr_acc, 7);
        tick();
        chk("r_beep_on", beep_out, 1);
        pulse_full();
        chk("r_done_after", done, 1);
        tick();

        // Zero beeps: done straight away, timer untouched.
        s0 = starts; d0 = dones;
        request(4'd0, 32'd9, 32'd9, 16'd3);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_start", tmr_start, 0);
        chk("z_acc_kept", tmr_acc, 7);
        tick();
        chk("z_done_drop", done, 0);
        tick();
        chk("z_no_starts", starts - s0, 0);
        chk("z_one_done", dones - d0, 1);

        // Clamped intervals and steady tone.
        request(4'd2, 32'd0, 32'd1, 16'd0);
        chk("c_acc_on", tmr_acc, 2);
        chk("c_start", tmr_start, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("c_steady", beep_out, 1);
            tick();
        end
        pulse_full();
        chk("c_acc_off", tmr_acc, 2);
        chk("c_start_off", tmr_start, 1);
        tick(); tick();
        pulse_full();
        chk("c_acc_on2", tmr_acc, 2);
        tick();
        chk("c_steady2", beep_out, 1);
        pulse_full();
        chk("c_done", done, 1);
        tick();

        // Abort in the second OFF interval, then a stale timer pulse.
        s0 = starts; d0 = dones;
        request(4'd3, 32'd6, 32'd4, 16'd1);
        tick(); ticks(2);
        pulse_full();
        tick();
        pulse_full();
        tick(); ticks(2);
        pulse_full();
        tick();
        chk("a_busy_before", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_busy", busy, 0);
        chk("a_beep", beep_out, 0);
        chk("a_start", tmr_start, 0);
        chk("a_done", done, 0);
        pulse_full();
        chk("a_stale_start", tmr_start, 0);
        chk("a_stale_busy", busy, 0);
        ticks(3);
        chk("a_still_idle", busy, 0);
        chk("a_start_count", starts - s0, 4);
        chk("a_no_done", dones - d0, 0);

        // req and abort together in IDLE: request dropped.
        beep_num = 4'd1; on_cyc = 32'd3;
        req = 1'b1; abort = 1'b1;
        tick();
        req = 1'b0; abort = 1'b0;
        chk("ra_busy", busy, 0);
        chk("ra_start", tmr_start, 0);
        tick();

        // Stray tmr_full in IDLE and req while busy are both ignored.
        s0 = starts; d0 = dones;
        pulse_full();
        chk("i_full_busy", busy, 0);
        chk("i_full_start", tmr_start, 0);
        request(4'd1, 32'd8, 32'd8, 16'd3);
        tick();
        beep_num = 4'd5;
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("i_req_busy", busy, 1);
        chk("i_req_start", tmr_start, 0);
        ticks(2);
        pulse_full();
        chk("i_done", done, 1);
        chk("i_busy_drop", busy, 0);
        tick(); ticks(2);
        chk("i_not_queued", busy, 0);
        chk("i_start_count", starts - s0, 1);
        chk("i_done_count", dones - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
